// File: rtl/arb_pkg.sv
// Shared types for the AXI-lite bus arbiters.
// States, grant owner and transaction kind.
package arb_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RD_ADDR = 3'd1,
      RD_DATA = 3'd2,
      WR_REQ  = 3'd3,
      WR_RESP = 3'd4
   } arb_state_t;

   typedef enum logic {
      M0 = 1'b0,
      M1 = 1'b1
   } grant_t;

   typedef enum logic {
      RD = 1'b0,
      WR = 1'b1
   } kind_t;

endpackage

// File: rtl/axi_lite_if.sv
// AXI4-lite channel bundle.
// master drives requests, slave drives responses.
interface axi_lite_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);

   logic [ADDR_W-1:0]   awaddr;
   logic                awvalid;
   logic                awready;
   logic [DATA_W-1:0]   wdata;
   logic [DATA_W/8-1:0] wstrb;
   logic                wvalid;
   logic                wready;
   logic [1:0]          bresp;
   logic                bvalid;
   logic                bready;
   logic [ADDR_W-1:0]   araddr;
   logic                arvalid;
   logic                arready;
   logic [DATA_W-1:0]   rdata;
   logic [1:0]          rresp;
   logic                rvalid;
   logic                rready;

   modport master (
      output awaddr, awvalid, wdata, wstrb, wvalid,
      output bready, araddr, arvalid, rready,
      input  awready, wready, bresp, bvalid,
      input  arready, rdata, rresp, rvalid
   );

   modport slave (
      input  awaddr, awvalid, wdata, wstrb, wvalid,
      input  bready, araddr, arvalid, rready,
      output awready, wready, bresp, bvalid,
      output arready, rdata, rresp, rvalid
   );

endinterface

// File: rtl/arb_pick.sv
// Two-way request picker shared by the bus arbiters.
// A lone requester wins; a tie goes to the one not in last_grant.
module arb_pick
   import arb_pkg::*;
(
   input  logic   req0,
   input  logic   req1,
   input  grant_t last_grant,
   output grant_t grant
);

   // choose the owner for the next transaction
   always_comb begin
      grant = M1;
      if (req0 && req1)
         grant = (last_grant == M1) ? M0 : M1;
      else if (req0)
         grant = M0;
   end

endmodule

// File: rtl/axi_lite_arbiter.sv
// Two-master AXI-lite arbiter, one transaction in flight.
// ARB_ROUND_ROBIN_EN: round-robin ties, else m1 fixed priority.
module axi_lite_arbiter
   import arb_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input logic        clk,
   input logic        reset,
   axi_lite_if.slave  m0,
   axi_lite_if.slave  m1,
   axi_lite_if.master sl
);

   arb_state_t state;
   grant_t     grant;
   kind_t      kind;
   logic       aw_done;
   logic       w_done;

   logic   req0;
   logic   req1;
   grant_t nxt_grant;
   grant_t pick_hint;
   logic   nxt_rd;

   logic [ADDR_W-1:0]   g_araddr;
   logic [ADDR_W-1:0]   g_awaddr;
   logic [DATA_W-1:0]   g_wdata;
   logic [DATA_W/8-1:0] g_wstrb;
   logic g_arvalid;
   logic g_awvalid;
   logic g_wvalid;
   logic g_rready;
   logic g_bready;

   logic ph_ar;
   logic ph_r;
   logic ph_aw;
   logic ph_w;
   logic ph_b;
   logic sel0;
   logic sel1;
   logic ar_hs;
   logic r_hs;
   logic aw_hs;
   logic w_hs;
   logic b_hs;

   // wvalid alone never opens a transaction
   assign req0 = m0.arvalid | m0.awvalid;
   assign req1 = m1.arvalid | m1.awvalid;

`ifdef ARB_ROUND_ROBIN_EN
   grant_t last_grant;

   // starts at M0 so the first tie goes to m1,
   // matching the fixed-priority build
   always_ff @(posedge clk) begin
      if (!reset)
         last_grant <= M0;
      else if (state == IDLE && (req0 || req1))
         last_grant <= nxt_grant;
   end

   assign pick_hint = last_grant;
`else
   // a fixed hint of M0 makes every tie go to m1
   assign pick_hint = M0;
`endif

   arb_pick u_pick (
      .req0       (req0),
      .req1       (req1),
      .last_grant (pick_hint),
      .grant      (nxt_grant)
   );

   // read wins over write inside the chosen master
   assign nxt_rd = (nxt_grant == M1) ? m1.arvalid
                                     : m0.arvalid;

   // route the granted master's request side
   always_comb begin
      if (grant == M1) begin
         g_araddr  = m1.araddr;
         g_awaddr  = m1.awaddr;
         g_wdata   = m1.wdata;
         g_wstrb   = m1.wstrb;
         g_arvalid = m1.arvalid;
         g_awvalid = m1.awvalid;
         g_wvalid  = m1.wvalid;
         g_rready  = m1.rready;
         g_bready  = m1.bready;
      end else begin
         g_araddr  = m0.araddr;
         g_awaddr  = m0.awaddr;
         g_wdata   = m0.wdata;
         g_wstrb   = m0.wstrb;
         g_arvalid = m0.arvalid;
         g_awvalid = m0.awvalid;
         g_wvalid  = m0.wvalid;
         g_rready  = m0.rready;
         g_bready  = m0.bready;
      end
   end

   assign ph_ar = (state == RD_ADDR) && (kind == RD);
   assign ph_r  = (state == RD_DATA) && (kind == RD);
   assign ph_aw = (state == WR_REQ) && (kind == WR) && !aw_done;
   assign ph_w  = (state == WR_REQ) && (kind == WR) && !w_done;
   assign ph_b  = (state == WR_RESP) && (kind == WR);
   assign sel0  = (grant == M0);
   assign sel1  = (grant == M1);

   assign ar_hs = ph_ar && g_arvalid && sl.arready;
   assign r_hs  = ph_r && g_rready && sl.rvalid;
   assign aw_hs = ph_aw && g_awvalid && sl.awready;
   assign w_hs  = ph_w && g_wvalid && sl.wready;
   assign b_hs  = ph_b && g_bready && sl.bvalid;

   assign sl.araddr  = g_araddr;
   assign sl.arvalid = ph_ar && g_arvalid;
   assign sl.rready  = ph_r && g_rready;
   assign sl.awaddr  = g_awaddr;
   assign sl.awvalid = ph_aw && g_awvalid;
   assign sl.wdata   = g_wdata;
   assign sl.wstrb   = g_wstrb;
   assign sl.wvalid  = ph_w && g_wvalid;
   assign sl.bready  = ph_b && g_bready;

   assign m0.arready = sel0 && ph_ar && sl.arready;
   assign m0.rvalid  = sel0 && ph_r && sl.rvalid;
   assign m0.awready = sel0 && ph_aw && sl.awready;
   assign m0.wready  = sel0 && ph_w && sl.wready;
   assign m0.bvalid  = sel0 && ph_b && sl.bvalid;
   assign m0.rdata   = sl.rdata;
   assign m0.rresp   = sl.rresp;
   assign m0.bresp   = sl.bresp;

   assign m1.arready = sel1 && ph_ar && sl.arready;
   assign m1.rvalid  = sel1 && ph_r && sl.rvalid;
   assign m1.awready = sel1 && ph_aw && sl.awready;
   assign m1.wready  = sel1 && ph_w && sl.wready;
   assign m1.bvalid  = sel1 && ph_b && sl.bvalid;
   assign m1.rdata   = sl.rdata;
   assign m1.rresp   = sl.rresp;
   assign m1.bresp   = sl.bresp;

   // transaction sequencer; grant frozen until back in IDLE
   always_ff @(posedge clk) begin
      if (!reset) begin
         state   <= IDLE;
         grant   <= M0;
         kind    <= RD;
         aw_done <= 1'b0;
         w_done  <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (req0 || req1) begin
                  grant <= nxt_grant;
                  kind  <= nxt_rd ? RD : WR;
                  state <= nxt_rd ? RD_ADDR : WR_REQ;
               end
            end
            RD_ADDR: if (ar_hs) state <= RD_DATA;
            RD_DATA: if (r_hs) state <= IDLE;
            WR_REQ: begin
               if (aw_hs) aw_done <= 1'b1;
               if (w_hs) w_done <= 1'b1;
               if ((aw_done || aw_hs) && (w_done || w_hs))
                  state <= WR_RESP;
            end
            WR_RESP: begin
               if (b_hs) begin
                  state   <= IDLE;
                  aw_done <= 1'b0;
                  w_done  <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/axi_lite_arbiter.md
AXI_LITE_ARBITER -- requirements
Module: axi_lite_arbiter

Interface
REQ-001 SHALL declare parameter: ADDR_W, 32, address width carried by axi_lite_if.
REQ-002 SHALL declare parameter: DATA_W, 32, data width carried by axi_lite_if.
REQ-003 SHALL declare port: clk  input  1  single clock; all state updates on posedge clk.
REQ-004 SHALL declare port: reset  input  1  reset, synchronous and active-low (asserted when 0, sampled on posedge clk).
REQ-005 SHALL declare port: m0  axi_lite_if.slave  -  upstream requester 0 (IFU side).
REQ-006 SHALL declare port: m1  axi_lite_if.slave  -  upstream requester 1 (LSU side).
REQ-007 SHALL declare port: sl  axi_lite_if.master  -  shared downstream device (UART/SRAM/xbar).

Function
REQ-008 SHALL implement the FSM states IDLE, RD_ADDR, RD_DATA, WR_REQ and WR_RESP, with exactly one transaction outstanding at a time.
REQ-009 Request detection in IDLE SHALL be: master requests read if arvalid=1, write if awvalid=1; wvalid alone SHALL NOT count as a request.
REQ-010 Within one master, read SHALL win over write when arvalid and awvalid are both high.
REQ-011 Master selection in IDLE SHALL be:
- without ARB_ROUND_ROBIN_EN: fixed priority, m1 over m0;
- with ARB_ROUND_ROBIN_EN: see REQ-025.
REQ-012 Grant and kind SHALL be registered on the IDLE exit edge:
- IDLE -> RD_ADDR for a read grant;
- IDLE -> WR_REQ for a write grant;
- no request: stay IDLE.
REQ-013 In IDLE, all readies to both masters SHALL be 0 and all valids to sl SHALL be 0; the arbitration latency is exactly 1 cycle.
REQ-014 In RD_ADDR:
- granted master's ar channel forwarded combinationally to sl;
- sl.arready forwarded to the granted master;
- on arvalid&&arready, go to RD_DATA.
REQ-015 In RD_DATA:
- sl r channel forwarded to the granted master;
- sl.rready = granted rready;
- on rvalid&&rready, go to IDLE.
REQ-016 In WR_REQ:
- aw and w SHALL be forwarded independently;
- registered flags aw_done and w_done SHALL be set on the respective handshake;
- after its flag is set, that channel's sl valid and master ready SHALL be 0;
- go to WR_RESP when both flags are set, including the case where both handshakes occur in the same cycle.
REQ-017 In WR_RESP:
- sl b channel forwarded to the granted master;
- on bvalid&&bready, go to IDLE;
- aw_done and w_done cleared.
REQ-018 The non-granted master SHALL see arready, awready, wready, rvalid and bvalid equal to 0 at all times.
REQ-019 rdata, rresp and bresp SHALL be driven to both masters from sl; only the valids SHALL be gated.
REQ-020 Slave error responses (rresp/bresp=2'b10) SHALL be passed through unchanged; the arbiter SHALL NOT generate responses itself.
REQ-021 A request arriving at the grant edge SHALL wait; the grant SHALL NOT change until return to IDLE.

Reset
REQ-022 On reset=0 at posedge clk, the block SHALL enter IDLE, clear aw_done and w_done, and set last_grant=m1.
REQ-023 Reset asserted mid-transaction SHALL abandon the transaction; all output valids and readies SHALL read 0 from the next cycle.

Configuration
REQ-024 Macro ARB_ROUND_ROBIN_EN SHALL select the arbitration policy.
REQ-025 When ARB_ROUND_ROBIN_EN is defined:
- a last_grant register SHALL be updated on each IDLE exit;
- on simultaneous requests, grant SHALL go to the master not in last_grant;
- a single requester SHALL always be granted.
REQ-026 When ARB_ROUND_ROBIN_EN is undefined, last_grant SHALL be absent, the policy SHALL be fixed priority (m1 wins), and m0 starvation SHALL be permitted.

Structure
REQ-027 Shared package arb_pkg SHALL hold arb_state_t (the five states), grant_t (M0/M1) and kind_t (RD/WR).
REQ-028 Sub-module: one combinational arb_pick (inputs req0, req1, last_grant; output grant) SHALL be used, reused by later bus arbiters; everything else SHALL reside in axi_lite_arbiter.

Verification
REQ-029 Single read: m0 araddr=0x8000_0000, slave rdata=0xDEADBEEF after 2 cycles -> m0 receives rdata=0xDEADBEEF, rresp=0; m1 rvalid stays 0.
REQ-030 Simultaneous: m0 read and m1 write to 0xa00003f8, wdata=0x41 in the same cycle -> m1 is served first in both modes (at reset last_grant=m1, so under REQ-025 m0 would be granted first; reconcile before implementation); with ARB_ROUND_ROBIN_EN, the next simultaneous pair goes to the other master.
REQ-031 Write with w 3 cycles before aw -> exactly one sl.wvalid handshake, then sl.aw handshake, then WR_RESP; bresp=0 reaches m1.
REQ-032 Slave bresp=2'b10 for awaddr 0xa00003f9 -> m1 bresp=2'b10; FSM returns to IDLE.
REQ-033 reset=0 during RD_DATA -> next cycle all valids and readies are 0 and the state is IDLE; a new m0 read then completes normally.
REQ-034 Without ARB_ROUND_ROBIN_EN, m1 requesting continuously -> m0 is never granted; with the macro, grants alternate m0/m1.
